ryu_move_sequencer: RTL



---
 rtl/ryu_pkg.sv | 28 ++
 rtl/ryu_pixel_mux.sv | 66 ++++++
 rtl/ryu_move_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ryu_pkg.sv
// Shared types for the Ryu move sequencer: FSM states, sprite encodings, frame counter width.
// Optional kick path is enabled by defining RYU_KICK_EN.
package ryu_pkg;

    localparam int FRAME_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WINDUP   = 3'd1,
        ACTIVE   = 3'd2,
        RECOVER  = 3'd3,
        COOLDOWN = 3'd4,
        BLOCK    = 3'd5
    } move_state_t;

    typedef enum logic [1:0] {
        SPR_IDLE  = 2'd0,
        SPR_PUNCH = 2'd1,
        SPR_KICK  = 2'd2,
        SPR_BLOCK = 2'd3
    } sprite_sel_t;

    // Phase counter load value: a phase of n frames counts n-1 down to 0.
    function automatic logic [FRAME_CNT_W-1:0] phase_load(input int n);
        return FRAME_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/ryu_pixel_mux.sv
// Registered pixel mux: picks the {on, rgb} pair named by sprite_sel, 1 vga_clk latency.
// Transparent pixels output black; kick sprite only selectable when RYU_KICK_EN is defined.
module ryu_pixel_mux
    import ryu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  sprite_sel_t sprite_sel_i,
    input  logic        idle_on_i,
    input  logic        punch_on_i,
    input  logic        kick_on_i,
    input  logic        block_on_i,
    input  logic [11:0] idle_rgb_i,
    input  logic [11:0] punch_rgb_i,
    input  logic [11:0] kick_rgb_i,
    input  logic [11:0] block_rgb_i,
    output logic        ryu_on_o,
    output logic [11:0] rgb_o
);

    logic        on_d;
    logic [11:0] rgb_d;
    logic        on_q;
    logic [11:0] rgb_q;

    always_comb begin
        on_d  = idle_on_i;
        rgb_d = idle_rgb_i;
        case (sprite_sel_i)
            SPR_PUNCH: begin
                on_d  = punch_on_i;
                rgb_d = punch_rgb_i;
            end
`ifdef RYU_KICK_EN
            SPR_KICK: begin
                on_d  = kick_on_i;
                rgb_d = kick_rgb_i;
            end
`endif
            SPR_BLOCK: begin
                on_d  = block_on_i;
                rgb_d = block_rgb_i;
            end
            default: ;
        endcase
    end

`ifndef RYU_KICK_EN
    logic unused_kick;
    assign unused_kick = ^{kick_on_i, kick_rgb_i};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            on_q  <= 1'b0;
            rgb_q <= 12'h000;
        end else begin
            on_q  <= on_d;
            rgb_q <= on_d ? rgb_d : 12'h000;
        end
    end

    assign ryu_on_o = on_q;
    assign rgb_o    = rgb_q;

endmodule

// File: rtl/ryu_move_sequencer.sv
// Frame-rate move FSM for Ryu: latches punch/kick edges in IDLE, sequences windup/active/recover/cooldown.
// State changes only on vsync falling edge; kick path compiled in only with RYU_KICK_EN.
module ryu_move_sequencer
    import ryu_pkg::*;
#(
    parameter int WINDUP_FRAMES   = 2,
    parameter int ACTIVE_FRAMES   = 4,
    parameter int RECOVER_FRAMES  = 3,
    parameter int COOLDOWN_FRAMES = 6
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        vs,
    input  logic        punch_req,
    input  logic        kick_req,
    input  logic        block_req,
    input  logic        idle_on,
    input  logic        punch_on,
    input  logic        kick_on,
    input  logic        block_on,
    input  logic [11:0] idle_rgb,
    input  logic [11:0] punch_rgb,
    input  logic [11:0] kick_rgb,
    input  logic [11:0] block_rgb,
    output logic [1:0]  sprite_sel,
    output logic        hit_active,
    output logic        busy,
    output logic        ryu_on,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam logic [FRAME_CNT_W-1:0] WINDUP_LOAD   = phase_load(WINDUP_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] ACTIVE_LOAD   = phase_load(ACTIVE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] RECOVER_LOAD  = phase_load(RECOVER_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COOLDOWN_LOAD = phase_load(COOLDOWN_FRAMES);

    move_state_t             state_q, state_d;
    sprite_sel_t             move_q, move_d;
    logic [FRAME_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    vs_q;
    logic                    punch_q;
    logic                    pend_punch_q, pend_punch_d;
    sprite_sel_t             sel_q, sel_d;
    logic                    hit_q;
    logic                    busy_q;
    logic                    frame_tick;
    logic                    punch_edge;
    logic                    kick_edge;
    logic                    pend_kick_now;

    assign frame_tick = vs_q & ~vs;
    assign punch_edge = punch_req & ~punch_q;

`ifdef RYU_KICK_EN
    logic kick_q;
    logic pend_kick_q, pend_kick_d;
    assign kick_edge     = kick_req & ~kick_q;
    assign pend_kick_now = pend_kick_q;
`else
    logic unused_kick_req;
    assign unused_kick_req = kick_req;
    assign kick_edge       = 1'b0;
    assign pend_kick_now   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        move_d       = move_q;
        cnt_d        = cnt_q;
        pend_punch_d = pend_punch_q;
`ifdef RYU_KICK_EN
        pend_kick_d  = pend_kick_q;
        if (state_q == IDLE) pend_kick_d = pend_kick_q | kick_edge;
`endif
        // Edges are only remembered while idle; a move being taken below wipes them.
        if (state_q == IDLE) pend_punch_d = pend_punch_q | punch_edge;

        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (block_req || pend_punch_q || pend_kick_now) begin
                        pend_punch_d = 1'b0;
`ifdef RYU_KICK_EN
                        pend_kick_d  = 1'b0;
`endif
                        cnt_d        = WINDUP_LOAD;
                        if (block_req) begin
                            state_d = BLOCK;
                        end else begin
                            state_d = WINDUP;
                            move_d  = pend_punch_q ? SPR_PUNCH : SPR_KICK;
                        end
                    end
                end
                WINDUP, ACTIVE, RECOVER, COOLDOWN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - FRAME_CNT_W'(1);
                    end else begin
                        case (state_q)
                            WINDUP:  begin state_d = ACTIVE;   cnt_d = ACTIVE_LOAD;   end
                            ACTIVE:  begin state_d = RECOVER;  cnt_d = RECOVER_LOAD;  end
                            RECOVER: begin state_d = COOLDOWN; cnt_d = COOLDOWN_LOAD; end
                            default: begin state_d = IDLE;     cnt_d = '0;            end
                        endcase
                    end
                end
                BLOCK: begin
                    if (!block_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next state so they move one cycle after the tick.
    always_comb begin
        sel_d = SPR_IDLE;
        case (state_d)
            WINDUP, ACTIVE, RECOVER: sel_d = move_d;
            BLOCK:                   sel_d = SPR_BLOCK;
            default:                 ;
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            move_q       <= SPR_IDLE;
            cnt_q        <= '0;
            vs_q         <= 1'b1;
            punch_q      <= 1'b0;
            pend_punch_q <= 1'b0;
            sel_q        <= SPR_IDLE;
            hit_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            move_q       <= move_d;
            cnt_q        <= cnt_d;
            vs_q         <= vs;
            punch_q      <= punch_req;
            pend_punch_q <= pend_punch_d;
            sel_q        <= sel_d;
            hit_q        <= (state_d == ACTIVE);
            busy_q       <= (state_d != IDLE);
        end
    end

`ifdef RYU_KICK_EN
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            kick_q      <= 1'b0;
            pend_kick_q <= 1'b0;
        end else begin
            kick_q      <= kick_req;
            pend_kick_q <= pend_kick_d;
        end
    end
`endif

    logic [11:0] rgb;

    ryu_pixel_mux u_pixel_mux (
        .clk_i        (vga_clk),
        .rst_i        (reset),
        .sprite_sel_i (sel_q),
        .idle_on_i    (idle_on),
        .punch_on_i   (punch_on),
        .kick_on_i    (kick_on),
        .block_on_i   (block_on),
        .idle_rgb_i   (idle_rgb),
        .punch_rgb_i  (punch_rgb),
        .kick_rgb_i   (kick_rgb),
        .block_rgb_i  (block_rgb),
        .ryu_on_o     (ryu_on),
        .rgb_o        (rgb)
    );

    assign sprite_sel         = sel_q;
    assign hit_active         = hit_q;
    assign busy               = busy_q;
    assign {red, green, blue} = rgb;

endmodule
